// File: rtl/switch_input_buffer_pkg.sv
// Shared definitions for the switch ingress buffer: route codes, port count
// and flit width derivation.
package switch_input_buffer_pkg;

  localparam int ROUTE_LEN = 3;
  localparam int PORT_NUM  = 6;

  typedef logic [ROUTE_LEN-1:0] route_t;

  localparam route_t DIR_XPOS = 3'd1;
  localparam route_t DIR_YPOS = 3'd2;
  localparam route_t DIR_ZPOS = 3'd3;
  localparam route_t DIR_XNEG = 3'd4;
  localparam route_t DIR_YNEG = 3'd5;
  localparam route_t DIR_ZNEG = 3'd6;

  function automatic int flit_width(input int valid_bit_pos);
    return valid_bit_pos + 1;
  endfunction

  function automatic int flit_child_width(input int valid_bit_pos, input int lg_numprocs);
    return flit_width(valid_bit_pos) + lg_numprocs;
  endfunction

  // Codes 0 and 7 name no direction port.
  function automatic logic route_legal(input route_t route);
    return (route >= DIR_XPOS) && (route <= DIR_ZNEG);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: circular RAM plus a registered head, with the
// head counted in the occupancy.
module sync_fifo_fwft #(
  parameter int WIDTH    = 8,
  parameter int LG_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [WIDTH-1:0]    push_data,
  input  logic                pop,
  output logic                full,
  output logic [WIDTH-1:0]    head_data,
  output logic                head_valid,
  output logic [LG_DEPTH:0]   count
);

  localparam int DEPTH = 1 << LG_DEPTH;
  localparam int PW    = (LG_DEPTH > 0) ? LG_DEPTH : 1;
  localparam int CW    = LG_DEPTH + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] head_q, head_d;
  logic             head_valid_q, head_valid_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             mem_we;
  logic             push_ok, pop_ok, ram_empty;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count_q == CW'(DEPTH));
  assign push_ok   = push && !full;
  assign pop_ok    = pop && head_valid_q;
  // RAM holds everything except the head register.
  assign ram_empty = (count_q == CW'(head_valid_q));

  always_comb begin
    head_d       = head_q;
    head_valid_d = head_valid_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_we       = 1'b0;
    count_d      = count_q + CW'(push_ok) - CW'(pop_ok);
    if (!head_valid_q || pop_ok) begin
      if (!ram_empty) begin
        head_d       = mem_q[rd_ptr_q];
        head_valid_d = 1'b1;
        rd_ptr_d     = ptr_next(rd_ptr_q);
        if (push_ok) begin
          mem_we   = 1'b1;
          wr_ptr_d = ptr_next(wr_ptr_q);
        end
      end else if (push_ok) begin
        // Bypass straight into the head so an empty buffer costs one cycle.
        head_d       = push_data;
        head_valid_d = 1'b1;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (push_ok) begin
      mem_we   = 1'b1;
      wr_ptr_d = ptr_next(wr_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      head_valid_q <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  assign head_data  = head_q;
  assign head_valid = head_valid_q;
  assign count      = count_q;

endmodule

// File: rtl/switch_input_buffer.sv
// Per-port ingress buffer feeding one lane of the collective switch.
// Define ROUTE_CHECK_EN to drop flits with illegal route codes and flag route_err.
module switch_input_buffer
  import switch_input_buffer_pkg::*;
#(
  parameter int ValidBitPos = 81,
  parameter int lg_numprocs = 3,
  parameter int RoutePos    = 0,
  parameter int LG_DEPTH    = 2,
  localparam int FlitChildWidth = flit_child_width(ValidBitPos, lg_numprocs)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [FlitChildWidth-1:0] link_in,
  input  logic                      link_valid,
  output logic                      link_ready,
  output logic [FlitChildWidth-1:0] flit_out,
  output logic [ROUTE_LEN-1:0]      route_out,
  output logic                      valid_out,
  input  logic                      grant,
  output logic [LG_DEPTH:0]         occupancy,
  output logic                      route_err
);

  logic   full;
  logic   accept;
  logic   push;
  route_t route_in;

  assign link_ready = !full;
  assign accept     = link_valid && link_ready && link_in[ValidBitPos];
  assign route_in   = link_in[RoutePos +: ROUTE_LEN];

`ifdef ROUTE_CHECK_EN
  logic route_err_q, route_err_d;

  assign push = accept && route_legal(route_in);

  always_comb begin
    route_err_d = route_err_q;
    if (accept && !route_legal(route_in)) route_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) route_err_q <= 1'b0;
    else      route_err_q <= route_err_d;
  end

  assign route_err = route_err_q;
`else
  logic unused_route;

  assign push         = accept;
  assign unused_route = ^route_in;
  assign route_err    = 1'b0;
`endif

  sync_fifo_fwft #(
    .WIDTH    (FlitChildWidth),
    .LG_DEPTH (LG_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .push       (push),
    .push_data  (link_in),
    .pop        (grant),
    .full       (full),
    .head_data  (flit_out),
    .head_valid (valid_out),
    .count      (occupancy)
  );

  // Route rides in the flit, so it is registered together with the head.
  assign route_out = flit_out[RoutePos +: ROUTE_LEN];

endmodule
